// File: rtl/g_serial_subtractor32.sv
//------------------------------------------------------------------------------
// Module   : g_serial_subtractor32
// Purpose  : Digit-serial subtractor, Out = In1 - In2 - BI, one DIGIT per enabled cycle
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module g_serial_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             BI,
  input  logic             Enable,
  output logic [WIDTH-1:0] Out,
  output logic             BO,
  output logic             V,
  output logic             Done,
  output logic             Busy,
  output logic             Ready
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH % DIGIT) != 0 || NDIG < 2) begin : g_bad_digit
      $error("g_serial_subtractor32: DIGIT must divide WIDTH with at least two digits");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_borrow;
  logic             r_msb_a;
  logic             r_msb_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_bo;
  logic             r_v;
  logic             r_done;
  logic             r_busy;

  logic [DIGIT:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_last;

  // Operands shift right so the current digit always sits in the low bits;
  // result digits enter at the top so digit 0 lands at bit 0 after NDIG steps.
  assign w_diff = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};
  assign w_res  = {w_diff[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_borrow <= 1'b0;
      r_msb_a  <= 1'b0;
      r_msb_b  <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_bo     <= 1'b0;
      r_v      <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a      <= In1;
            r_b      <= In2;
            r_borrow <= BI;
            r_msb_a  <= In1[WIDTH-1];
            r_msb_b  <= In2[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (Enable) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_borrow <= w_diff[DIGIT];
            r_acc    <= w_res;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
              r_out   <= w_res;
              r_bo    <= w_diff[DIGIT];
              r_v     <= (r_msb_a ^ r_msb_b) & (w_res[WIDTH-1] ^ r_msb_a);
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Out   = r_out;
  assign BO    = r_bo;
  assign V     = r_v;
  assign Done  = r_done;
  assign Busy  = r_busy;
  assign Ready = ~r_busy;

endmodule

`default_nettype wire

// File: tb/tb_g_serial_subtractor32.sv
//------------------------------------------------------------------------------
// Module   : tb_g_serial_subtractor32
// Purpose  : Randomised scoreboard bench for the digit-serial subtractor
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_g_serial_subtractor32;

  localparam int NDIG = 8;

  logic        CLK;
  logic        RST_N;
  logic        Start;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        BI;
  logic        Enable;
  logic [31:0] Out;
  logic        BO;
  logic        V;
  logic        Done;
  logic        Busy;
  logic        Ready;

  g_serial_subtractor32 #(.WIDTH(32), .DIGIT(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .In1(In1), .In2(In2), .BI(BI),
    .Enable(Enable), .Out(Out), .BO(BO), .V(V), .Done(Done), .Busy(Busy), .Ready(Ready)
  );

  typedef struct {
    logic [31:0] out;
    logic        bo;
    logic        v;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_done = -10;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain wide unsigned and signed arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    exp_t        m;
    logic [32:0] d;
    longint      r;
    d = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    r = longint'($signed(a)) - longint'($signed(b)) - longint'({31'd0, bi});
    m.out = d[31:0];
    m.bo  = d[32];
    m.v   = (r < -64'sd2147483648) || (r > 64'sd2147483647);
    m.cyc = 0;
    return m;
  endfunction

  always @(negedge CLK) begin
    if (RST_N) begin
      if (Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", Out, e.out);
          chk("bo", {31'd0, BO}, {31'd0, e.bo});
          chk("v", {31'd0, V}, {31'd0, e.v});
          chk("done_cycle", cyc, e.cyc);
          chk("ready_in_done", {31'd0, Ready}, 32'd0);
        end
        last_done = cyc;
      end else if (cyc == last_done + 1) begin
        chk("ready_after_done", {30'd0, Ready, Busy}, 32'd2);
      end
    end
  end

  // mode: 0 Enable held, 1 random Enable, 2 five-cycle stall after 4 digits, 3 Start pulses during RUN
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                        input int mode, input int abort_after);
    int   en[$];
    int   ones;
    int   guard;
    int   e0;
    bit   rdy;
    exp_t e;
    ones = 0;
    if (mode == 2) begin
      for (int i = 0; i < 4; i++) en.push_back(1);
      for (int i = 0; i < 5; i++) en.push_back(0);
      for (int i = 0; i < 4; i++) en.push_back(1);
    end else begin
      while (ones < NDIG) begin
        int bit_en;
        bit_en = (mode == 1) ? int'($urandom_range(0, 3) != 0) : 1;
        en.push_back(bit_en);
        ones += bit_en;
      end
    end
    In1 = a; In2 = b; BI = bi; Start = 1'b1;
    guard = 0;
    do begin
      rdy = Ready;
      @(posedge CLK); #1;
      guard++;
    end while (!rdy && guard < 40);
    if (!rdy) begin
      chk("start_accept_timeout", 32'd0, 32'd1);
      Start = 1'b0;
      return;
    end
    e0 = cyc;
    Start = 1'b0;
    e = model(a, b, bi);
    e.cyc = e0 + en.size();
    sb.push_back(e);
    for (int i = 0; i < en.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        RST_N = 1'b0;
        #1;
        chk("abort_out", Out, 32'd0);
        chk("abort_flags", {28'd0, Busy, Ready, Done, BO}, 32'h4);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        void'(sb.pop_back());
        Enable = 1'b0;
        return;
      end
      Enable = en[i][0];
      In1 = $urandom; In2 = $urandom; BI = 1'($urandom);
      if (mode == 3) Start = (i < en.size() - 1) ? 1'($urandom) : 1'b0;
      @(posedge CLK); #1;
    end
    Start  = 1'b0;
    Enable = 1'($urandom);
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    RST_N = 1'b0; Start = 1'b0; In1 = '0; In2 = '0; BI = 1'b0; Enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_out", Out, 32'd0);
    chk("reset_flags", {27'd0, Busy, Ready, Done, BO, V}, 32'h8);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    run_op(32'h3E037E1A, 32'h5ED86C3D, 1'b1, 0, -1);
    run_op(32'h00000000, 32'h00000001, 1'b0, 0, -1);
    run_op(32'h80000000, 32'h00000001, 1'b0, 0, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, -1);
    run_op(32'h3E037E1A, 32'h5ED86C3D, 1'b1, 2, -1);
    run_op(32'h3E037E1A, 32'h5ED86C3D, 1'b1, 3, -1);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 3);
    run_op(32'h12345678, 32'h87654321, 1'b0, 0, -1);
    for (int n = 0; n < 25; n++) begin
      run_op($urandom, $urandom, 1'($urandom), (n % 4 == 3) ? 3 : 1, -1);
    end
    Enable = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    finish_run();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    total++;
    finish_run();
  end

endmodule

`default_nettype wire
